// File: rtl/dsp_pkg.sv
// Shared types for the dsp block family.
package dsp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2,
        OUT     = 2'd3
    } meter_state_e;

endpackage

// File: rtl/serial_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, QUOT_WIDTH cycles after start_i.
// The caller guarantees the quotient fits QUOT_WIDTH bits (dividend >> QUOT_WIDTH < divisor).
module serial_divider #(
    parameter int DIVIDEND_WIDTH = 41,
    parameter int DIVISOR_WIDTH  = 24,
    parameter int QUOT_WIDTH     = 16
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      start_i,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [QUOT_WIDTH-1:0]     quot_o
);

    localparam int HI_W = DIVIDEND_WIDTH - QUOT_WIDTH;
    localparam int CW   = $clog2(QUOT_WIDTH + 1);

    logic [DIVISOR_WIDTH-1:0] rem_q, div_q;
    logic [QUOT_WIDTH-1:0]    sh_q;
    logic [CW-1:0]            cnt_q;
    logic [DIVISOR_WIDTH:0]   trial;
    logic [HI_W-1:0]          hi;
    logic                     fits;

    // sh_q shifts dividend bits out of the top while quotient bits enter at the bottom
    assign hi     = dividend_i[DIVIDEND_WIDTH-1:QUOT_WIDTH];
    assign trial  = {rem_q, sh_q[QUOT_WIDTH-1]};
    assign fits   = trial >= {1'b0, div_q};
    assign quot_o = sh_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rem_q  <= '0;
            div_q  <= '0;
            sh_q   <= '0;
            cnt_q  <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (start_i) begin
                rem_q  <= DIVISOR_WIDTH'(hi);
                sh_q   <= dividend_i[QUOT_WIDTH-1:0];
                div_q  <= divisor_i;
                cnt_q  <= CW'(QUOT_WIDTH);
                busy_o <= 1'b1;
            end else if (busy_o) begin
                rem_q <= fits ? DIVISOR_WIDTH'(trial - {1'b0, div_q}) : trial[DIVISOR_WIDTH-1:0];
                sh_q  <= {sh_q[QUOT_WIDTH-2:0], fits};
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/tone_freq_meter.sv
// Tone frequency meter: counts valid samples over PERIODS hysteresis zero crossings and
// divides (PERIODS << PHASE_WIDTH) by the count. Define TONE_FREQ_METER_ROUND_EN to round.
module tone_freq_meter
    import dsp_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int PHASE_WIDTH = 16,
    parameter int PERIODS     = 4,
    parameter int HYST        = 256,
    parameter int CNT_WIDTH   = 24
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          tvalid_i,
    input  logic signed [DATA_WIDTH-1:0]  tdata_i,
    output logic                          tvalid_o,
    output logic        [PHASE_WIDTH-1:0] tdata_o,
    output logic                          busy_o,
    output logic                          timeout_o
);

    localparam int DVD_W = PHASE_WIDTH + CNT_WIDTH + 1;
    localparam int XW    = $clog2(PERIODS + 1);
    localparam logic signed [DATA_WIDTH-1:0] HYST_P = DATA_WIDTH'(HYST);
    localparam logic signed [DATA_WIDTH-1:0] HYST_N = -HYST_P;

    meter_state_e           state_q;
    logic                   armed_q;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_nxt;
    logic [XW-1:0]          xcnt_q;
    logic                   sample_ok, crossing, final_x, cnt_max, div_start;
    logic                   div_busy, div_done;
    logic [PHASE_WIDTH-1:0] quot;
    logic [DVD_W-1:0]       dividend;

    // Samples arriving in DIVIDE/OUT never touch the detector
    assign sample_ok = tvalid_i && (state_q == IDLE || state_q == MEASURE);
    assign crossing  = sample_ok && armed_q && (tdata_i >= HYST_P);
    assign final_x   = crossing && (xcnt_q == XW'(PERIODS - 1));
    assign cnt_max   = &cnt_q;
    assign cnt_nxt   = cnt_q + 1'b1;
    assign div_start = (state_q == MEASURE) && final_x && !cnt_max;
    assign busy_o    = (state_q == DIVIDE);

    always_comb begin
        dividend = DVD_W'(PERIODS) << PHASE_WIDTH;
`ifdef TONE_FREQ_METER_ROUND_EN
        dividend = dividend + DVD_W'(cnt_nxt >> 1);
`endif
    end

    serial_divider #(
        .DIVIDEND_WIDTH (DVD_W),
        .DIVISOR_WIDTH  (CNT_WIDTH),
        .QUOT_WIDTH     (PHASE_WIDTH)
    ) u_div (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (cnt_nxt),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quot_o     (quot)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= IDLE;
            armed_q   <= 1'b0;
            cnt_q     <= '0;
            xcnt_q    <= '0;
            tvalid_o  <= 1'b0;
            tdata_o   <= '0;
            timeout_o <= 1'b0;
        end else begin
            tvalid_o  <= 1'b0;
            timeout_o <= 1'b0;
            if (sample_ok) begin
                if (crossing)
                    armed_q <= 1'b0;
                else if (tdata_i < HYST_N)
                    armed_q <= 1'b1;
            end
            case (state_q)
                IDLE: if (crossing) begin
                    state_q <= MEASURE;
                    cnt_q   <= '0;
                    xcnt_q  <= '0;
                end
                MEASURE: if (tvalid_i) begin
                    // overflow wins over a crossing on the same sample
                    if (cnt_max) begin
                        state_q   <= IDLE;
                        timeout_o <= 1'b1;
                        armed_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_nxt;
                        if (crossing) begin
                            xcnt_q <= xcnt_q + 1'b1;
                            if (final_x) state_q <= DIVIDE;
                        end
                    end
                end
                DIVIDE: if (div_done && !div_busy) state_q <= OUT;
                OUT: begin
                    tdata_o  <= quot;
                    tvalid_o <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tone_freq_meter.sv
// Directed bench for tone_freq_meter: square, gapped, dds-like sine, alternating, noise,
// counter-overflow (CNT_WIDTH=8 instance) and mid-divide reset scenarios.
module tb_tone_freq_meter;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               tvalid = 1'b0;
    logic signed [15:0] tdata = '0;
    logic               tv_o, busy, tmo, tv8, busy8, tmo8;
    logic [15:0]        td_o, td8;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pv[$], pc[$], tc[$], pv8[$], tc8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tone_freq_meter u_dut (
        .clk_i(clk), .rstn_i(rstn), .tvalid_i(tvalid), .tdata_i(tdata),
        .tvalid_o(tv_o), .tdata_o(td_o), .busy_o(busy), .timeout_o(tmo)
    );

    tone_freq_meter #(.CNT_WIDTH(8)) u_dut8 (
        .clk_i(clk), .rstn_i(rstn), .tvalid_i(tvalid), .tdata_i(tdata),
        .tvalid_o(tv8), .tdata_o(td8), .busy_o(busy8), .timeout_o(tmo8)
    );

    always @(negedge clk) begin
        if (tv_o) begin pv.push_back(int'(td_o)); pc.push_back(cyc); end
        if (tmo)  tc.push_back(cyc);
        if (tv8)  pv8.push_back(int'(td8));
        if (tmo8) tc8.push_back(cyc);
    end

    task automatic drive(input logic v, input int d);
        @(negedge clk);
        tvalid = v;
        tdata  = d[15:0];
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; tvalid = 1'b0; tdata = '0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // 8 low / 8 high square; e_cyc is the edge accepting sample 72 (5th crossing)
    task automatic feed_square(input bit gap, input int nsamp, output int e_cyc);
        e_cyc = 0;
        for (int i = 0; i < nsamp; i++) begin
            int v;
            v = ((i % 16) < 8) ? -1000 : 1000;
            if (gap) drive(1'b0, -v);
            drive(1'b1, v);
            if (i == 72) e_cyc = cyc + 1;
        end
        drive(1'b0, 0);
    endtask

    task automatic wait_pulses(input int target, input int limit);
        for (int k = 0; k < limit && pv.size() < target; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total += 5;
        if (tv_o !== 1'b0)  begin bad++; $display("FAIL reset_tvalid: got %b want 0", tv_o); end
        if (td_o !== 16'd0) begin bad++; $display("FAIL reset_tdata: got %0d want 0", td_o); end
        if (busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (tmo !== 1'b0)   begin bad++; $display("FAIL reset_timeout: got %b want 0", tmo); end
        if (td8 !== 16'd0)  begin bad++; $display("FAIL reset_tdata8: got %0d want 0", td8); end
        rstn = 1'b1;
    endtask

    task automatic test_square();
        int n0, n8, e;
        do_reset();
        n0 = pv.size(); n8 = pv8.size();
        feed_square(1'b0, 80, e);
        wait_pulses(n0 + 1, 40);
        repeat (20) @(negedge clk);
        total++;
        if (pv.size() != n0 + 1) begin bad++; $display("FAIL square_count: got %0d want 1", pv.size() - n0); end
        if (pv.size() > n0) begin
            total += 2;
            if (pv[n0] != 4096) begin bad++; $display("FAIL square_value: got %0d want 4096", pv[n0]); end
            if (pc[n0] - e != 18) begin bad++; $display("FAIL square_latency: got %0d want 18", pc[n0] - e); end
        end
        total++;
        if (pv8.size() != n8 + 1 || pv8[$] != 4096)
            begin bad++; $display("FAIL square_dut8: got n=%0d want n=1 value 4096", pv8.size() - n8); end
    endtask

    task automatic test_reset_mid();
        int n0, e;
        n0 = pv.size();
        feed_square(1'b0, 73, e);
        repeat (4) @(negedge clk);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b want 1", busy); end
        rstn = 1'b0;
        #1;
        total += 4;
        if (tv_o !== 1'b0)  begin bad++; $display("FAIL mid_tvalid: got %b want 0", tv_o); end
        if (td_o !== 16'd0) begin bad++; $display("FAIL mid_tdata: got %0d want 0", td_o); end
        if (busy !== 1'b0)  begin bad++; $display("FAIL mid_busy_rst: got %b want 0", busy); end
        if (tmo !== 1'b0)   begin bad++; $display("FAIL mid_timeout: got %b want 0", tmo); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        total++;
        if (pv.size() != n0) begin bad++; $display("FAIL mid_discard: got %0d pulses want 0", pv.size() - n0); end
        feed_square(1'b0, 80, e);
        wait_pulses(n0 + 1, 40);
        total++;
        if (pv.size() != n0 + 1 || pv[$] != 4096)
            begin bad++; $display("FAIL mid_rerun: got n=%0d want n=1 value 4096", pv.size() - n0); end
    endtask

    task automatic test_gapped();
        int n0, e;
        do_reset();
        n0 = pv.size();
        feed_square(1'b1, 80, e);
        wait_pulses(n0 + 1, 40);
        repeat (30) @(negedge clk);
        total++;
        if (pv.size() != n0 + 1) begin bad++; $display("FAIL gapped_count: got %0d want 1", pv.size() - n0); end
        if (pv.size() > n0) begin
            total++;
            if (pv[n0] != 4096) begin bad++; $display("FAIL gapped_value: got %0d want 4096", pv[n0]); end
        end
    endtask

    task automatic test_dds();
        int n0, p, s;
        do_reset();
        n0 = pv.size();
        p = 0;
        for (int n = 0; n < 360; n++) begin
            s = $rtoi($sin(6.283185307179586 * p / 65536.0) * 16000.0);
            drive(1'b1, s);
            p = (p + 2000) % 65536;
        end
        drive(1'b0, 0);
        wait_pulses(n0 + 2, 40);
        total++;
        if (pv.size() != n0 + 2) begin bad++; $display("FAIL dds_count: got %0d want 2", pv.size() - n0); end
        for (int i = n0; i < pv.size(); i++) begin
            total++;
            if (pv[i] < 1998 || pv[i] > 2002)
                begin bad++; $display("FAIL dds_value: got %0d want 2000+-2", pv[i]); end
        end
    endtask

    task automatic test_alternating();
        int n0, e;
        do_reset();
        n0 = pv.size();
        e = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i % 2 == 0) ? -1000 : 1000);
            if (i == 9) e = cyc + 1;
        end
        drive(1'b0, 0);
        wait_pulses(n0 + 1, 40);
        total++;
        if (pv.size() != n0 + 1) begin bad++; $display("FAIL alt_count: got %0d want 1", pv.size() - n0); end
        if (pv.size() > n0) begin
            total += 2;
            if (pv[n0] != 32768) begin bad++; $display("FAIL alt_value: got %0d want 32768", pv[n0]); end
            if (pc[n0] - e != 18) begin bad++; $display("FAIL alt_latency: got %0d want 18", pc[n0] - e); end
        end
    endtask

    task automatic test_noise();
        int n0, t0;
        do_reset();
        n0 = pv.size(); t0 = tc.size();
        for (int i = 0; i < 200; i++) drive(1'b1, int'($urandom_range(200)) - 100);
        drive(1'b0, 0);
        repeat (25) @(negedge clk);
        total += 3;
        if (pv.size() != n0) begin bad++; $display("FAIL noise_pulse: got %0d want 0", pv.size() - n0); end
        if (tc.size() != t0) begin bad++; $display("FAIL noise_timeout: got %0d want 0", tc.size() - t0); end
        if (busy !== 1'b0)   begin bad++; $display("FAIL noise_busy: got %b want 0", busy); end
    endtask

    task automatic test_timeout();
        int n8, t8, t0, e;
        do_reset();
        n8 = pv8.size(); t8 = tc8.size(); t0 = tc.size();
        drive(1'b1, -1000);
        drive(1'b1, 1000);
        e = cyc + 1;
        for (int i = 0; i < 300; i++) drive(1'b1, 1000);
        drive(1'b0, 0);
        repeat (25) @(negedge clk);
        total += 4;
        if (tc8.size() != t8 + 1) begin bad++; $display("FAIL timeout_count: got %0d want 1", tc8.size() - t8); end
        else if (tc8[t8] - e != 256) begin bad++; $display("FAIL timeout_at: got %0d want 256", tc8[t8] - e); end
        if (pv8.size() != n8) begin bad++; $display("FAIL timeout_pulse: got %0d want 0", pv8.size() - n8); end
        if (busy8 !== 1'b0)   begin bad++; $display("FAIL timeout_busy: got %b want 0", busy8); end
        if (tc.size() != t0)  begin bad++; $display("FAIL timeout_wide: got %0d want 0", tc.size() - t0); end
        feed_square(1'b0, 80, e);
        repeat (40) @(negedge clk);
        total++;
        if (pv8.size() != n8 + 1 || pv8[$] != 4096)
            begin bad++; $display("FAIL timeout_rerun: got n=%0d want n=1 value 4096", pv8.size() - n8); end
    endtask

    initial begin
        test_reset();
        test_square();
        test_reset_mid();
        test_gapped();
        test_dds();
        test_alternating();
        test_noise();
        test_timeout();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
